// File: rtl/seg_scan_display.sv
// seg_scan_display: eight-digit hex scanner over one frame-consistent snapshot of the selected CPU word.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan_display #(
  parameter int TICK_DIV = 100000,
  parameter int TICK_W   = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ShiftA,
  input  logic [3:0]  ShiftB,
  input  logic [31:0] SyscallOut,
  input  logic [31:0] total_cycle,
  input  logic [15:0] unconditional,
  input  logic [15:0] conditional,
  input  logic [31:0] DataMemory,
  output logic [7:0]  AN,
  output logic        CA,
  output logic        CB,
  output logic        CC,
  output logic        CD,
  output logic        CE,
  output logic        CF,
  output logic        CG,
  output logic        DP,
  output logic [3:0]  dmaddr_light
);
  logic [TICK_W-1:0] cnt_q, cnt_d;
  logic [2:0]        dig_q, dig_d;
  logic [31:0]       shadow_q, shadow_d;
  logic [1:0]        mode_q, mode_d;
  logic [7:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [3:0]        dm_q;
  logic              tick, wrap, blank;
  logic [31:0]       sel, word;
  logic [4:0]        base;
  logic [3:0]        nib;
  logic [1:0]        frame_mode;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: seg_of = 7'b0000001;
      4'h1: seg_of = 7'b1001111;
      4'h2: seg_of = 7'b0010010;
      4'h3: seg_of = 7'b0000110;
      4'h4: seg_of = 7'b1001100;
      4'h5: seg_of = 7'b0100100;
      4'h6: seg_of = 7'b0100000;
      4'h7: seg_of = 7'b0001111;
      4'h8: seg_of = 7'b0000000;
      4'h9: seg_of = 7'b0000100;
      4'hA: seg_of = 7'b0001000;
      4'hB: seg_of = 7'b1100000;
      4'hC: seg_of = 7'b0110001;
      4'hD: seg_of = 7'b1000010;
      4'hE: seg_of = 7'b0110000;
      default: seg_of = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    tick       = cnt_q == TICK_W'(TICK_DIV - 1);
    cnt_d      = tick ? '0 : cnt_q + TICK_W'(1);
    wrap       = dig_q == 3'd7;
    dig_d      = tick ? dig_q + 3'd1 : dig_q;
    sel        = ShiftA == 2'b00 ? SyscallOut :
                 ShiftA == 2'b01 ? total_cycle :
                 ShiftA == 2'b10 ? {unconditional, conditional} : DataMemory;
    shadow_d   = tick && wrap ? sel : shadow_q;
    mode_d     = tick && wrap ? ShiftA : mode_q;
    // The digit-0 slot is driven in the same tick that takes the snapshot, so it reads the live selection.
    word       = wrap ? sel : shadow_q;
    frame_mode = wrap ? ShiftA : mode_q;
    base       = {dig_d, 2'b00};
    nib        = word[base +: 4];
`ifdef SEG_LZ_BLANK_EN
    blank      = (dig_d != 3'd0) && ((word >> base) == 32'd0);
`else
    blank      = 1'b0;
`endif
    an_d       = tick ? (blank ? 8'hFF : ~(8'h01 << dig_d)) : an_q;
    seg_d      = tick ? (blank ? 7'h7F : seg_of(nib)) : seg_q;
    dp_d       = tick ? ~(!blank && dig_d == 3'd4 && frame_mode == 2'b10) : dp_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      dig_q    <= 3'd7;
      shadow_q <= '0;
      mode_q   <= 2'b00;
      an_q     <= 8'hFF;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      dm_q     <= 4'h0;
    end else begin
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      shadow_q <= shadow_d;
      mode_q   <= mode_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      dm_q     <= ShiftB;
    end
  end

  assign AN                       = an_q;
  assign {CA, CB, CC, CD, CE, CF, CG} = seg_q;
  assign DP                       = dp_q;
  assign dmaddr_light             = dm_q;
endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: directed frames checked against a slot-arithmetic model plus literal expectations.
module tb_seg_scan_display;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ShiftA = 2'b00;
  logic [3:0]  ShiftB = 4'h0;
  logic [31:0] SyscallOut = 32'h0, total_cycle = 32'h0, DataMemory = 32'h0;
  logic [15:0] unconditional = 16'h0, conditional = 16'h0;
  logic [7:0]  AN;
  logic        CA, CB, CC, CD, CE, CF, CG, DP;
  logic [3:0]  dmaddr_light;
  logic [6:0]  seg;
  int          total = 0, bad = 0;

  seg_scan_display #(.TICK_DIV(4), .TICK_W(3)) dut (
    .clk(clk), .rst(rst), .ShiftA(ShiftA), .ShiftB(ShiftB),
    .SyscallOut(SyscallOut), .total_cycle(total_cycle),
    .unconditional(unconditional), .conditional(conditional),
    .DataMemory(DataMemory), .AN(AN),
    .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .CF(CF), .CG(CG),
    .DP(DP), .dmaddr_light(dmaddr_light)
  );

  always #5 clk = ~clk;
  assign seg = {CA, CB, CC, CD, CE, CF, CG};

  logic [6:0] tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                           7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] m);
    return m == 2'd0 ? SyscallOut : m == 2'd1 ? total_cycle :
           m == 2'd2 ? {unconditional, conditional} : DataMemory;
  endfunction

  function automatic logic lz(input logic [31:0] w, input int d);
`ifdef SEG_LZ_BLANK_EN
    return d > 0 && (w >> (4 * d)) == 32'd0;
`else
    return 1'b0;
`endif
  endfunction

  // Model: after reset, every 4th clock drives slot (n/4 - 1) mod 8; slot 0 takes a new snapshot.
  int          k = 0;
  logic        mv = 1'b0;
  logic [31:0] snap;
  logic [1:0]  smode;
  logic [7:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_dm;

  always @(posedge clk) begin
    int n, s;
    logic [31:0] w;
    logic [1:0] m;
    mv   <= mv | rst;
    e_dm <= rst ? 4'h0 : ShiftB;
    if (rst) begin
      k <= 0; snap <= 0; smode <= 0; e_an <= 8'hFF; e_seg <= 7'h7F; e_dp <= 1'b1;
    end else begin
      n = k + 1;
      k <= n;
      if (n % 4 == 0) begin
        s = (n / 4 + 7) % 8;
        w = s == 0 ? pick(ShiftA) : snap;
        m = s == 0 ? ShiftA : smode;
        snap  <= w;
        smode <= m;
        if (lz(w, s)) begin
          e_an <= 8'hFF; e_seg <= 7'h7F; e_dp <= 1'b1;
        end else begin
          e_an  <= 8'hFF ^ (8'h01 << s);
          e_seg <= tab[(w >> (4 * s)) & 32'hF];
          e_dp  <= !(s == 4 && m == 2'd2);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mv) begin
      chk("model_an", {24'h0, AN}, {24'h0, e_an});
      chk("model_seg", {25'h0, seg}, {25'h0, e_seg});
      chk("model_dp", {31'h0, DP}, {31'h0, e_dp});
      chk("model_dmaddr", {28'h0, dmaddr_light}, {28'h0, e_dm});
    end
  end

  task automatic wait_an(input logic [7:0] v);
    int i = 0;
    while (AN !== v && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (AN !== v) begin
      chk("wait_an_timeout", {24'h0, AN}, {24'h0, v});
      $display("FAIL sync: no frame boundary within bound");
      $fatal(1, "frame sync lost");
    end
  endtask

  task automatic sync_frame();
    wait_an(8'h7F);
    wait_an(8'hFE);
  endtask

  // Entered at the first negedge of slot 0; leaves at the last negedge of slot 7.
  task automatic check_frame(input logic [31:0] w, input logic [1:0] m);
    for (int d = 0; d < 8; d++)
      for (int c = 0; c < 4; c++) begin
        if (d != 0 || c != 0) @(negedge clk);
        chk("frame_an", {24'h0, AN}, {24'h0, lz(w, d) ? 8'hFF : 8'hFF ^ (8'h01 << d)});
        chk("frame_seg", {25'h0, seg}, {25'h0, lz(w, d) ? 7'h7F : tab[(w >> (4 * d)) & 32'hF]});
        chk("frame_dp", {31'h0, DP}, {31'h0, !(d == 4 && m == 2'd2 && !lz(w, d))});
      end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("reset_an", {24'h0, AN}, 32'hFF);
      chk("reset_seg", {25'h0, seg}, 32'h7F);
    end
    @(negedge clk);
    chk("first_tick_an", {24'h0, AN}, 32'hFE);
    chk("first_tick_seg", {25'h0, seg}, 32'b0000001);

    SyscallOut = 32'h89ABCDEF;
    ShiftB = 4'h5;
    sync_frame();
    chk("lit_F_seg", {25'h0, seg}, 32'b0111000);
    check_frame(32'h89ABCDEF, 2'd0);
    chk("lit_8_seg", {25'h0, seg}, 32'b0000000);
    chk("lit_7F_an", {24'h0, AN}, 32'h7F);

    ShiftA = 2'b10;
    unconditional = 16'h0012;
    conditional = 16'h0034;
    sync_frame();
    chk("lit_4_seg", {25'h0, seg}, 32'b1001100);
    check_frame(32'h00120034, 2'd2);

    ShiftA = 2'b00;
    SyscallOut = 32'h13572468;
    DataMemory = 32'h00000007;
    sync_frame();
    repeat (12) @(negedge clk);
    chk("switch_at_d3_an", {24'h0, AN}, 32'hF7);
    ShiftA = 2'b11;
    repeat (8) @(negedge clk);
    chk("held_mode_an", {24'h0, AN}, 32'hDF);
    chk("held_mode_seg", {25'h0, seg}, 32'b0100100);
    sync_frame();
    chk("new_mode_seg", {25'h0, seg}, 32'b0001111);

    ShiftA = 2'b00;
    SyscallOut = 32'h00000105;
    sync_frame();
    check_frame(32'h00000105, 2'd0);

    repeat (21) @(negedge clk);
    chk("pre_reset_an", {24'h0, AN}, 32'hDF);
    rst = 1'b1;
    ShiftB = 4'hA;
    @(negedge clk);
    chk("midrst_an", {24'h0, AN}, 32'hFF);
    chk("midrst_seg", {25'h0, seg}, 32'h7F);
    chk("midrst_dp", {31'h0, DP}, 32'h1);
    chk("midrst_dmaddr", {28'h0, dmaddr_light}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("dmaddr_after_rst", {28'h0, dmaddr_light}, 32'hA);
    repeat (12) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
